// File: rtl/div8191_pkg.sv
// Shared constants and elaboration helpers for the divide-by-8191 pipeline.
package div8191_pkg;

    localparam int unsigned DIVISOR = 8191;
    localparam int unsigned FOLD_W  = 13;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned MIN_K   = 13;

    // Folds needed to bring a w-bit value below 2^(FOLD_W+1); each fold
    // bounds the width to max(w-FOLD_W, FOLD_W)+1.
    function automatic int unsigned num_folds(input int unsigned w);
        int unsigned cur;
        int unsigned n;
        cur = w;
        n   = 0;
        while (cur > FOLD_W + 1) begin
            cur = ((cur - FOLD_W > FOLD_W) ? cur - FOLD_W : FOLD_W) + 1;
            n   = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/mersenne_fold.sv
// One combinational Mersenne fold: v = a*2^13 + b  ->  partial quotient a, residue a+b.
module mersenne_fold
    import div8191_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0]        v,
    output logic [W-FOLD_W-1:0] a,
    output logic [W-1:0]        s
);

    // a + b never exceeds v, so the residue fits in the input width.
    assign a = v[W-1:FOLD_W];
    assign s = W'(a) + W'(v[FOLD_W-1:0]);

endmodule

// File: rtl/divider_8191_core.sv
// Pipelined quotient/remainder by 8191 using shift-and-add folding; fixed
// three-clock latency from the input sampling edge, one operation per clock.
module divider_8191_core
    import div8191_pkg::*;
#(
    parameter int unsigned K = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [K+31:0] x,
    output logic          out_valid,
    output logic [31:0]   q,
    output logic [K-1:0]  r
);

    localparam int unsigned XW  = K + 32;
    localparam int unsigned QW  = XW - FOLD_W + 1;
    localparam int unsigned NF  = num_folds(XW);
    localparam int unsigned NF1 = (NF + 1) / 2;
    localparam int unsigned NF2 = NF - NF1;

    if (K < MIN_K) begin : g_k_check
        $error("divider_8191_core: K must be at least 13");
    end

    logic [LATENCY-1:0] vld;
    logic [XW-1:0]      s0_x;
    logic [XW-1:0]      s1_v;
    logic [QW-1:0]      s1_q;
    logic [XW-1:0]      s2_v;
    logic [QW-1:0]      s2_q;
    logic [XW-1:0]      fix_v;
    logic [QW-1:0]      fix_q;

    // Valid shift register; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[LATENCY-2:0], in_valid};
        end
    end

    // First half of the fold chain, fed by the sampled dividend.
    for (genvar i = 0; i < NF1; i++) begin : g_f1
        logic [XW-1:0]        vin;
        logic [XW-1:0]        vout;
        logic [QW-1:0]        qin;
        logic [QW-1:0]        qout;
        logic [XW-FOLD_W-1:0] a;
        if (i == 0) begin : g_first
            assign vin = s0_x;
            assign qin = '0;
        end else begin : g_next
            assign vin = g_f1[i-1].vout;
            assign qin = g_f1[i-1].qout;
        end
        mersenne_fold #(.W(XW)) u_fold (
            .v (vin),
            .a (a),
            .s (vout)
        );
        assign qout = qin + QW'(a);
    end

    // Second half of the fold chain, continuing from the stage-1 registers.
    for (genvar i = 0; i < NF2; i++) begin : g_f2
        logic [XW-1:0]        vin;
        logic [XW-1:0]        vout;
        logic [QW-1:0]        qin;
        logic [QW-1:0]        qout;
        logic [XW-FOLD_W-1:0] a;
        if (i == 0) begin : g_first
            assign vin = s1_v;
            assign qin = s1_q;
        end else begin : g_next
            assign vin = g_f2[i-1].vout;
            assign qin = g_f2[i-1].qout;
        end
        mersenne_fold #(.W(XW)) u_fold (
            .v (vin),
            .a (a),
            .s (vout)
        );
        assign qout = qin + QW'(a);
    end

    // Data pipeline registers load only when their stage carries a valid op.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s0_x <= x;
        end
        if (vld[0]) begin
            s1_v <= g_f1[NF1-1].vout;
            s1_q <= g_f1[NF1-1].qout;
        end
        if (vld[1]) begin
            s2_v <= g_f2[NF2-1].vout;
            s2_q <= g_f2[NF2-1].qout;
        end
    end

    // Residue is below 2^14 here; at most two subtractions of 8191 remain.
    always_comb begin
        fix_v = s2_v;
        fix_q = s2_q;
        if (s2_v >= XW'(2 * DIVISOR)) begin
            fix_v = s2_v - XW'(2 * DIVISOR);
            fix_q = s2_q + QW'(2);
        end else if (s2_v >= XW'(DIVISOR)) begin
            fix_v = s2_v - XW'(DIVISOR);
            fix_q = s2_q + QW'(1);
        end
    end

    // Output registers hold their last result between valid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
        end else begin
            out_valid <= vld[LATENCY-1];
            if (vld[LATENCY-1]) begin
                q <= 32'(fix_q);
                r <= K'(fix_v);
            end
        end
    end

endmodule

// File: tb/tb_divider_8191_core.sv
// Randomised and directed checks of divider_8191_core against an arithmetic reference.
module tb_divider_8191_core;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] x;
    logic        out_valid;
    logic [31:0] q;
    logic [31:0] r;

    int checks;
    int errors;

    // Reference: inputs delayed three sampling edges, results by plain / and %.
    logic        dl_v [3];
    logic [63:0] dl_x [3];
    logic        exp_valid;
    logic [31:0] exp_q;
    logic [31:0] exp_r;

    divider_8191_core #(.K(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .q         (q),
        .r         (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [63:0] xi, input logic rs);
        logic [63:0] quo;
        rst      = rs;
        in_valid = v;
        x        = xi;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                dl_v[i] = 1'b0;
                dl_x[i] = '0;
            end
            exp_valid = 1'b0;
            exp_q     = '0;
            exp_r     = '0;
        end else begin
            exp_valid = dl_v[2];
            if (dl_v[2]) begin
                quo   = dl_x[2] / 64'd8191;
                exp_q = quo[31:0];
                exp_r = 32'(dl_x[2] % 64'd8191);
            end
            dl_v[2] = dl_v[1];
            dl_x[2] = dl_x[1];
            dl_v[1] = dl_v[0];
            dl_x[1] = dl_x[0];
            dl_v[0] = v;
            dl_x[0] = xi;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, {$urandom, $urandom}, 1'b1);
            checks++;
            if (out_valid !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got v=%b q=%h r=%h, expected v=0 q=0 r=0",
                         i, out_valid, q, r);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop[%0d]: got out_valid=%b, expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] dx [9];
        logic [31:0] dq [9];
        logic [31:0] dr [9];
        dx[0] = 64'd343564231;           dq[0] = 32'd41944;      dr[0] = 32'd927;
        dx[1] = 64'd8190;                dq[1] = 32'd0;          dr[1] = 32'd8190;
        dx[2] = 64'd8191;                dq[2] = 32'd1;          dr[2] = 32'd0;
        dx[3] = 64'd16382;               dq[3] = 32'd2;          dr[3] = 32'd0;
        dx[4] = 64'd0;                   dq[4] = 32'd0;          dr[4] = 32'd0;
        dx[5] = 64'h00001FFE_FFFFFFFF;   dq[5] = 32'hFFFFFFFF;   dr[5] = 32'd8190;
        dx[6] = 64'h00001FFF_00000000;   dq[6] = 32'd0;          dr[6] = 32'd0;
        dx[7] = 64'd16383;               dq[7] = 32'd2;          dr[7] = 32'd1;
        dx[8] = 64'd24573;               dq[8] = 32'd3;          dr[8] = 32'd0;
        for (int t = 0; t < 9; t++) begin
            step(1'b1, dx[t], 1'b0);
            for (int k = 1; k <= 3; k++) begin
                step(1'b0, '0, 1'b0);
                checks++;
                if (out_valid !== (k == 3)) begin
                    errors++;
                    $display("FAIL directed_latency[%0d] k=%0d: got out_valid=%b, expected %b",
                             t, k, out_valid, (k == 3));
                end
            end
            checks++;
            if (q !== dq[t] || r !== dr[t]) begin
                errors++;
                $display("FAIL directed[%0d] x=%h: got q=%h r=%0d, expected q=%h r=%0d",
                         t, dx[t], q, r, dq[t], dr[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] xi;
        for (int t = 0; t < 1003; t++) begin
            if (t < 1000) begin
                case ($urandom_range(0, 7))
                    0:       xi = 64'($urandom_range(0, 20000));
                    1:       xi = 64'hFFFFFFFF_FFFFFFFF - 64'($urandom_range(0, 100));
                    default: xi = {$urandom, $urandom};
                endcase
                step(1'b1, xi, 1'b0);
            end else begin
                step(1'b0, '0, 1'b0);
            end
            checks++;
            if (out_valid !== exp_valid || q !== exp_q || r !== exp_r) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%b q=%h r=%0d, expected v=%b q=%h r=%0d",
                         t, out_valid, q, r, exp_valid, exp_q, exp_r);
            end
            checks++;
            if (t >= 3 && out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_contig[%0d]: got out_valid=%b, expected 1", t, out_valid);
            end
        end
    endtask

    task automatic test_reset_flush();
        step(1'b1, {$urandom, $urandom}, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b0);
        step(1'b1, {$urandom, $urandom}, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
            errors++;
            $display("FAIL flush_reset: got v=%b q=%h r=%h, expected v=0 q=0 r=0",
                     out_valid, q, r);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
                errors++;
                $display("FAIL flush_after[%0d]: got v=%b q=%h r=%h, expected v=0 q=0 r=0",
                         i, out_valid, q, r);
            end
        end
    endtask

    task automatic test_gapped();
        logic pat [20];
        logic obs [23];
        for (int i = 0; i < 20; i++) begin
            pat[i] = (i % 5 == 0) || (i % 5 == 2) || (i % 5 == 3);
        end
        for (int t = 0; t < 23; t++) begin
            if (t < 20) step(pat[t], {$urandom, $urandom}, 1'b0);
            else        step(1'b0, '0, 1'b0);
            obs[t] = out_valid;
            checks++;
            if (out_valid !== exp_valid || q !== exp_q || r !== exp_r) begin
                errors++;
                $display("FAIL gapped[%0d]: got v=%b q=%h r=%0d, expected v=%b q=%h r=%0d",
                         t, out_valid, q, r, exp_valid, exp_q, exp_r);
            end
        end
        for (int t = 3; t < 23; t++) begin
            checks++;
            if (obs[t] !== pat[t-3]) begin
                errors++;
                $display("FAIL gapped_pattern[%0d]: got out_valid=%b, expected %b",
                         t, obs[t], pat[t-3]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        exp_valid = 1'b0;
        exp_q     = '0;
        exp_r     = '0;
        for (int i = 0; i < 3; i++) begin
            dl_v[i] = 1'b0;
            dl_x[i] = '0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flush();
        test_back_to_back();
        test_gapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
